// File: rtl/brent_kung_adder_pipe.sv
// Pipelined Brent-Kung prefix adder/subtractor with valid/ready flow control.
// Prefix levels are split into STAGES register slices; the last slice always registers the outputs.
module brent_kung_adder_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] op1_i,
  input  logic [WIDTH-1:0] op2_i,
  input  logic             carry_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o
);

  localparam int LOG  = $clog2(WIDTH);
  localparam int LVLS = 2 * LOG - 1;

  // Tree level after which inter-stage register b (1..STAGES-1) sits.
  function automatic int bpos(input int b);
    return (b * LVLS) / STAGES;
  endfunction

  // Register index sitting after tree level lvl, or 0 when that boundary is combinational.
  function automatic int reg_idx(input int lvl);
    int r;
    r = 0;
    for (int b = 1; b < STAGES; b++) begin
      if (bpos(b) == lvl) r = b;
    end
    return r;
  endfunction

  if ((WIDTH < 8) || (WIDTH > 128) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
    $error("brent_kung_adder_pipe: WIDTH must be a power of two in 8..128");
  end
  if ((STAGES < 1) || (STAGES > LVLS)) begin : g_bad_stages
    $error("brent_kung_adder_pipe: STAGES must be in 1..2*log2(WIDTH)-1");
  end

  // Handshake: an input is accepted when valid_i & ready_o, a result leaves when
  // valid_o & ready_i. The whole pipe shifts together on w_adv and freezes otherwise,
  // so ready_o is a combinational function of ready_i and the output valid bit.
  logic w_adv;
  assign w_adv   = ~valid_o | ready_i;
  assign ready_o = w_adv;

  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_p0;
  logic [WIDTH-1:0] w_g0;
  logic             w_cin;

  assign w_b   = sub_i ? ~op2_i : op2_i;
  assign w_cin = sub_i | carry_i;
  assign w_p0  = op1_i ^ w_b;
  // Carry-in folded into bit 0 generate so the tree yields full carries directly.
  assign w_g0  = (op1_i & w_b) | {{(WIDTH-1){1'b0}}, w_p0[0] & w_cin};

  for (genvar l = 1; l <= LVLS; l++) begin : g_lvl
    localparam int RI   = reg_idx(l - 1);
    localparam bit UP   = (l <= LOG);
    localparam int K    = UP ? l : (2 * LOG - l);
    localparam int HALF = 1 << (K - 1);

    logic [WIDTH-1:0] in_pp;
    logic [WIDTH-1:0] in_gg;
    logic [WIDTH-1:0] in_hp;
    logic             in_ci;
    logic [WIDTH-1:0] out_pp;
    logic [WIDTH-1:0] out_gg;
    logic [WIDTH-1:0] out_hp;
    logic             out_ci;

    if (RI != 0) begin : g_from_reg
      assign in_pp = g_reg[RI].r_pp;
      assign in_gg = g_reg[RI].r_gg;
      assign in_hp = g_reg[RI].r_hp;
      assign in_ci = g_reg[RI].r_ci;
    end else if (l == 1) begin : g_from_pre
      assign in_pp = w_p0;
      assign in_gg = w_g0;
      assign in_hp = w_p0;
      assign in_ci = w_cin;
    end else begin : g_from_prev
      assign in_pp = g_lvl[l-1].out_pp;
      assign in_gg = g_lvl[l-1].out_gg;
      assign in_hp = g_lvl[l-1].out_hp;
      assign in_ci = g_lvl[l-1].out_ci;
    end

    // Up-sweep builds power-of-two groups; down-sweep fills the remaining prefixes.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      localparam bit NODE = UP ? (((i + 1) % (2 * HALF)) == 0)
                               : ((((i + 1) % (2 * HALF)) == HALF) && (i >= 2 * HALF));
      if (NODE) begin : g_node
        assign out_gg[i] = in_gg[i] | (in_pp[i] & in_gg[i-HALF]);
        assign out_pp[i] = in_pp[i] & in_pp[i-HALF];
      end else begin : g_pass
        assign out_gg[i] = in_gg[i];
        assign out_pp[i] = in_pp[i];
      end
    end

    assign out_hp = in_hp;
    assign out_ci = in_ci;
  end

  for (genvar b = 1; b < STAGES; b++) begin : g_reg
    localparam int P = bpos(b);

    logic [WIDTH-1:0] r_pp;
    logic [WIDTH-1:0] r_gg;
    logic [WIDTH-1:0] r_hp;
    logic             r_ci;
    logic             r_vld;
    logic             w_vld_in;

    if (b == 1) begin : g_vld_first
      assign w_vld_in = valid_i;
    end else begin : g_vld_chain
      assign w_vld_in = g_reg[b-1].r_vld;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_pp  <= '0;
        r_gg  <= '0;
        r_hp  <= '0;
        r_ci  <= 1'b0;
        r_vld <= 1'b0;
      end else if (w_adv) begin
        r_pp  <= g_lvl[P].out_pp;
        r_gg  <= g_lvl[P].out_gg;
        r_hp  <= g_lvl[P].out_hp;
        r_ci  <= g_lvl[P].out_ci;
        r_vld <= w_vld_in;
      end
    end
  end

  logic w_last_vld;
  if (STAGES == 1) begin : g_out_direct
    assign w_last_vld = valid_i;
  end else begin : g_out_piped
    assign w_last_vld = g_reg[STAGES-1].r_vld;
  end

  logic [WIDTH-1:0] w_fg;
  logic [WIDTH-1:0] w_c;
  logic [WIDTH-1:0] w_sum;

  assign w_fg  = g_lvl[LVLS].out_gg;
  assign w_c   = {w_fg[WIDTH-2:0], g_lvl[LVLS].out_ci};
  assign w_sum = g_lvl[LVLS].out_hp ^ w_c;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o    <= 1'b0;
      sum_o      <= '0;
      carry_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else if (w_adv) begin
      valid_o    <= w_last_vld;
      sum_o      <= w_sum;
      carry_o    <= w_fg[WIDTH-1];
      // Signed overflow: carry into the MSB differs from carry out of it.
      overflow_o <= w_fg[WIDTH-1] ^ w_fg[WIDTH-2];
    end
  end

endmodule
